pcileech_tlps128_tx_arbiter: RTL and testbench

Packet-atomic arbiter that shares the single 128-bit PCIe TX TLP sink between NUM_SRC requesters: config completions, BAR completions and host-injected TLPs. It sits in the clk_pcie domain, between the TLP sources and the PCIe core TX stream. It selects one source per packet, round-robin with optional fixed priority for source 0, and holds the grant until tlast. It drives a registered output stage and reports packet count and sink-stall status.

---
 rtl/pcileech_tlps128_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_pcileech_tlps128_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_tlps128_tx_arbiter.sv
// pcileech_tlps128_tx_arbiter
// Packet-atomic arbiter sharing one 128-bit PCIe TX TLP sink between
// NUM_SRC sources (config completions on source 0, BAR completions,
// host-injected TLPs). One source is picked per packet, round-robin, with an
// optional fixed priority for source 0. The grant is held until tlast. The
// output beat is registered.
//
// Ports:
//   clk_pcie, rst          : PCIe user clock, async active-high reset
//   src_tdata/tkeep/tlast/tvalid/tready : per-source AXI-Stream slaves;
//                            source i occupies slice i of each packed bus
//   snk_tdata/tkeep/tlast/tvalid/tready : registered AXI-Stream master
//   grant_id               : current (or last) granted source
//   busy                   : high while a packet grant is held
//   pkt_cnt                : packets forwarded to the sink (wrapping)
//   stall_err              : sticky, mid-packet sink stall reached STALL_LIMIT
module pcileech_tlps128_tx_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter int          PRIO_SRC0   = 1,
    parameter logic [15:0] STALL_LIMIT = 16'd4096
) (
    input  logic                         clk_pcie,
    input  logic                         rst,
    input  logic [NUM_SRC*128-1:0]       src_tdata,
    input  logic [NUM_SRC*4-1:0]         src_tkeep,
    input  logic [NUM_SRC-1:0]           src_tlast,
    input  logic [NUM_SRC-1:0]           src_tvalid,
    output logic [NUM_SRC-1:0]           src_tready,
    output logic [127:0]                 snk_tdata,
    output logic [3:0]                   snk_tkeep,
    output logic                         snk_tlast,
    output logic                         snk_tvalid,
    input  logic                         snk_tready,
    output logic [$clog2(NUM_SRC)-1:0]   grant_id,
    output logic                         busy,
    output logic [15:0]                  pkt_cnt,
    output logic                         stall_err
);
    localparam int GW = $clog2(NUM_SRC);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  pick;
    logic           pick_vld;
    logic           out_ready;
    logic           beat_acc;
    logic           sel_valid;
    logic           sel_last;
    logic [127:0]   sel_data;
    logic [3:0]     sel_keep;
    logic [15:0]    stall_cnt, stall_nxt;
    logic           stall_cyc;

    // The output register can take a new beat when empty or draining.
    assign out_ready = ~snk_tvalid | snk_tready;
    assign busy      = (state == GRANT);
    assign beat_acc  = busy & sel_valid & out_ready;
    assign stall_cyc = busy & snk_tvalid & ~snk_tready;

    // Round-robin pick: first valid source after last_grant, wrapping.
    // Source 0 overrides the rotation when fixed priority is enabled.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!pick_vld && src_tvalid[i] &&
                    (i == (int'(last_grant) + k) % NUM_SRC)) begin
                    pick     = GW'(i);
                    pick_vld = 1'b1;
                end
            end
        end
        if ((PRIO_SRC0 != 0) && src_tvalid[0]) begin
            pick = '0;
        end
    end

    // Mux of the granted source; ready goes only to the granted source.
    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        sel_keep   = '0;
        src_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == GW'(i)) begin
                sel_valid     = src_tvalid[i];
                sel_last      = src_tlast[i];
                sel_data      = src_tdata[i*128 +: 128];
                sel_keep      = src_tkeep[i*4 +: 4];
                src_tready[i] = busy & out_ready;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = GRANT;
            GRANT:   if (beat_acc && sel_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall counter only runs while a packet is held and the sink refuses it.
    always_comb begin
        stall_nxt = stall_cnt;
        if (!busy || (snk_tvalid && snk_tready)) begin
            stall_nxt = '0;
        end else if (stall_cyc && stall_cnt != STALL_LIMIT) begin
            stall_nxt = stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            snk_tdata  <= '0;
            snk_tkeep  <= '0;
            snk_tlast  <= 1'b0;
            snk_tvalid <= 1'b0;
            pkt_cnt    <= '0;
            stall_cnt  <= '0;
            stall_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_nxt;
            if (state == IDLE && pick_vld) begin
                grant_id <= pick;
            end
            if (beat_acc && sel_last) begin
                last_grant <= grant_id;
            end
            if (beat_acc) begin
                snk_tdata  <= sel_data;
                snk_tkeep  <= sel_keep;
                snk_tlast  <= sel_last;
                snk_tvalid <= 1'b1;
            end else if (snk_tready) begin
                snk_tvalid <= 1'b0;
            end
            if (snk_tvalid && snk_tready && snk_tlast) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (stall_cyc && stall_nxt == STALL_LIMIT) begin
                stall_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcileech_tlps128_tx_arbiter.sv
// Self-checking bench for pcileech_tlps128_tx_arbiter (NUM_SRC=4,
// PRIO_SRC0=1, STALL_LIMIT=8). Source models feed per-source beat queues;
// every beat expected on the sink is pushed to a scoreboard queue and
// compared when the sink handshakes it.
module tb_pcileech_tlps128_tx_arbiter;
    localparam int NS = 4;

    logic              clk_pcie = 1'b0;
    logic              rst      = 1'b1;
    logic [NS*128-1:0] src_tdata  = '0;
    logic [NS*4-1:0]   src_tkeep  = '0;
    logic [NS-1:0]     src_tlast  = '0;
    logic [NS-1:0]     src_tvalid = '0;
    logic [NS-1:0]     src_tready;
    logic [127:0]      snk_tdata;
    logic [3:0]        snk_tkeep;
    logic              snk_tlast;
    logic              snk_tvalid;
    logic              snk_tready = 1'b1;
    logic [1:0]        grant_id;
    logic              busy;
    logic [15:0]       pkt_cnt;
    logic              stall_err;

    pcileech_tlps128_tx_arbiter #(
        .NUM_SRC(NS), .PRIO_SRC0(1), .STALL_LIMIT(16'd8)
    ) dut (
        .clk_pcie(clk_pcie), .rst(rst),
        .src_tdata(src_tdata), .src_tkeep(src_tkeep), .src_tlast(src_tlast),
        .src_tvalid(src_tvalid), .src_tready(src_tready),
        .snk_tdata(snk_tdata), .snk_tkeep(snk_tkeep), .snk_tlast(snk_tlast),
        .snk_tvalid(snk_tvalid), .snk_tready(snk_tready),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt), .stall_err(stall_err)
    );

    always #5 clk_pcie = ~clk_pcie;

    typedef struct {
        int           src;
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
    } beat_t;

    // inputs: set of sources with one packet each; expected: grant order
    typedef struct {
        logic [3:0]      mask;
        int              nbeats;
        int              norder;
        logic [3:0][1:0] ord;
    } vec_t;

    beat_t      srcq[$];
    beat_t      exp_q[$];
    int         hs_cyc[$];
    logic       hs_last[$];
    logic [NS-1:0] src_en = '1;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         pkt_seq = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic int find_src(input int s);
        for (int j = 0; j < srcq.size(); j++) if (srcq[j].src == s) return j;
        return -1;
    endfunction

    task automatic add_pkt(input int s, input int n, input bit push_exp);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.src  = s;
            b.data = {8'(s), 8'(pkt_seq), 8'(k), 8'h5A, $urandom, $urandom, $urandom};
            b.keep = (k == n - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
            b.last = (k == n - 1);
            srcq.push_back(b);
            if (push_exp) exp_q.push_back(b);
        end
        pkt_seq++;
    endtask

    // Queue the beats already staged for source s as the next expected packet.
    task automatic expect_src(input int s);
        for (int j = 0; j < srcq.size(); j++)
            if (srcq[j].src == s) exp_q.push_back(srcq[j]);
    endtask

    // Source models: retire handshaken beats, then present each source's next beat.
    initial begin : drv
        int j;
        forever begin
            @(posedge clk_pcie);
            if (rst) srcq.delete();
            else for (int i = 0; i < NS; i++)
                if (src_tvalid[i] && src_tready[i]) begin
                    j = find_src(i);
                    if (j >= 0) srcq.delete(j);
                end
            #1;
            for (int i = 0; i < NS; i++) begin
                j = find_src(i);
                if (j >= 0 && src_en[i] && !rst) begin
                    src_tvalid[i]           = 1'b1;
                    src_tdata[i*128 +: 128] = srcq[j].data;
                    src_tkeep[i*4 +: 4]     = srcq[j].keep;
                    src_tlast[i]            = srcq[j].last;
                end else begin
                    src_tvalid[i] = 1'b0;
                    src_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Sink monitor: scoreboard compare plus data-hold check under back-pressure.
    initial begin : mon
        beat_t        e;
        logic         hold_v;
        logic [127:0] hold_d;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(posedge clk_pcie);
            cyc++;
            if (!rst) begin
                if (hold_v && snk_tvalid) chk("hold_data", 256'(snk_tdata), 256'(hold_d));
                if (snk_tvalid && snk_tready) begin
                    hs_cyc.push_back(cyc);
                    hs_last.push_back(snk_tlast);
                    if (exp_q.size() == 0) fail_now("beat", $sformatf("unexpected beat %0h", snk_tdata));
                    else begin
                        e = exp_q.pop_front();
                        chk("beat", {snk_tkeep, snk_tlast, snk_tdata}, {e.keep, e.last, e.data});
                    end
                end
                hold_v = snk_tvalid && !snk_tready;
                hold_d = snk_tdata;
            end else hold_v = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        hs_cyc.delete();
        hs_last.delete();
        repeat (2) @(posedge clk_pcie);
        #2 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || srcq.size() != 0) && k < 300) begin
            @(posedge clk_pcie);
            k++;
        end
        if (k >= 300) fail_now(name, $sformatf("drain timeout, %0d beats outstanding", exp_q.size()));
        @(negedge clk_pcie);
    endtask

    task automatic wait_snk(input string name);
        int k;
        k = 0;
        @(negedge clk_pcie);
        while (!snk_tvalid && k < 50) begin
            @(negedge clk_pcie);
            k++;
        end
        if (!snk_tvalid) fail_now(name, "timeout waiting for snk_tvalid");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : test
        vec_t  vt[5];
        beat_t t1b[$];
        int    gap;

        vt[0] = '{4'b1110, 2, 3, {2'd0, 2'd3, 2'd2, 2'd1}};
        vt[1] = '{4'b1111, 1, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vt[2] = '{4'b1010, 3, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
        vt[3] = '{4'b0001, 1, 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        vt[4] = '{4'b1101, 2, 3, {2'd0, 2'd3, 2'd2, 2'd0}};

        // reset state
        @(negedge clk_pcie);
        chk("reset_out", {snk_tvalid, snk_tlast, snk_tkeep, snk_tdata, src_tready},
            256'd0);
        chk("reset_stat", {busy, stall_err, grant_id, pkt_cnt}, 256'd0);
        do_reset();

        // 1: single source, 3 beats, latency
        add_pkt(2, 3, 1);
        t1b = exp_q;
        @(posedge clk_pcie);
        @(negedge clk_pcie);
        chk("t1_n_ready", {busy, src_tready}, 256'd0);
        @(negedge clk_pcie);
        chk("t1_n1_ready", {busy, src_tready, snk_tvalid}, {1'b1, 4'b0100, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_pcie);
            chk($sformatf("t1_beat%0d", k), {snk_tvalid, snk_tlast, snk_tdata},
                {1'b1, t1b[k].last, t1b[k].data});
        end
        @(negedge clk_pcie);
        chk("t1_end", {pkt_cnt, grant_id, busy, snk_tvalid}, {16'd1, 2'd2, 1'b0, 1'b0});

        // table: simultaneous requests, expected grant order and bubbles
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int s = 0; s < NS; s++) if (vt[v].mask[s]) add_pkt(s, vt[v].nbeats, 0);
            for (int k = 0; k < vt[v].norder; k++) expect_src(int'(vt[v].ord[k]));
            wait_drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_cnt", v), {pkt_cnt, grant_id, busy},
                {16'(vt[v].norder), vt[v].ord[vt[v].norder-1], 1'b0});
            for (int k = 1; k < hs_cyc.size(); k++) begin
                gap = hs_cyc[k] - hs_cyc[k-1];
                chk($sformatf("vec%0d_gap%0d", v, k), 256'(gap), hs_last[k-1] ? 256'd2 : 256'd1);
            end
        end

        // 3: source 3 mid-packet when sources 0 and 1 request
        do_reset();
        add_pkt(3, 4, 1);
        repeat (3) @(posedge clk_pcie);
        #2;
        chk("t3_mid", {busy, grant_id}, {1'b1, 2'd3});
        add_pkt(0, 2, 1);
        add_pkt(1, 2, 1);
        wait_drain("t3");
        chk("t3_end", {pkt_cnt, grant_id}, {16'd3, 2'd1});

        // 3b: after source 0 was last served, priority still beats rotation
        do_reset();
        add_pkt(0, 1, 1);
        wait_drain("t3b_a");
        @(posedge clk_pcie);
        #2;
        add_pkt(0, 2, 1);
        add_pkt(1, 2, 1);
        wait_drain("t3b");
        chk("t3b_end", {pkt_cnt, grant_id}, {16'd3, 2'd1});

        // 4: sink back-pressure 1,0,0,1 during a 4-beat packet
        do_reset();
        add_pkt(2, 4, 1);
        wait_snk("t4");
        @(posedge clk_pcie);
        #2 snk_tready = 1'b0;
        @(negedge clk_pcie);
        chk("t4_stall_ready", {src_tready, snk_tvalid}, {4'b0000, 1'b1});
        @(posedge clk_pcie);
        #2;
        @(posedge clk_pcie);
        #2 snk_tready = 1'b1;
        wait_drain("t4");
        chk("t4_end", {pkt_cnt, 16'(hs_cyc.size())}, {16'd1, 16'd4});

        // 4b: granted source drops tvalid mid-packet; grant held
        do_reset();
        add_pkt(1, 4, 1);
        repeat (2) @(posedge clk_pcie);
        #2 src_en[1] = 1'b0;
        add_pkt(2, 2, 1);
        repeat (4) @(posedge clk_pcie);
        @(negedge clk_pcie);
        chk("t4b_hold", {busy, grant_id, snk_tvalid, src_tready[2]}, {1'b1, 2'd1, 1'b0, 1'b0});
        src_en[1] = 1'b1;
        wait_drain("t4b");
        chk("t4b_end", {pkt_cnt, grant_id}, {16'd2, 2'd2});

        // 5: stall counter with limit 8
        do_reset();
        snk_tready = 1'b0;
        add_pkt(1, 4, 1);
        wait_snk("t5");
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) chk("t5_s1", 256'(stall_err), 256'd0);
            if (k == 8) chk("t5_s8", 256'(stall_err), 256'd0);
            if (k == 9) chk("t5_s9", 256'(stall_err), 256'd1);
            if (k < 10) @(negedge clk_pcie);
        end
        @(posedge clk_pcie);
        #2 snk_tready = 1'b1;
        wait_drain("t5");
        repeat (3) @(negedge clk_pcie);
        chk("t5_end", {stall_err, pkt_cnt, busy}, {1'b1, 16'd1, 1'b0});

        // 6: reset mid-packet (no reset since test 5)
        add_pkt(0, 4, 1);
        wait_snk("t6");
        @(posedge clk_pcie);
        #2 rst = 1'b1;
        #1;
        chk("t6_async", {snk_tvalid, busy, pkt_cnt, stall_err, src_tready, grant_id}, 256'd0);
        exp_q.delete();
        hs_cyc.delete();
        hs_last.delete();
        repeat (2) @(posedge clk_pcie);
        #2 rst = 1'b0;
        add_pkt(0, 3, 1);
        wait_drain("t6");
        chk("t6_end", {pkt_cnt, grant_id, busy}, {16'd1, 2'd0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
